mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage. Sits beside the combinational ALU and owns the HI/LO registers.
- Accepts one operation per start pulse and holds busy for a fixed latency. The hazard unit stalls on busy, and on start in the issue cycle.
- Commits results to HI/LO at completion. mthi/mtlo write HI/LO directly; mfhi/mflo read the HI/LO outputs.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 clears all state
- start  input  1  qualifies md_op/A/B for one cycle
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- busy  output  1  operation in flight
- HI  output  32  HI register (registered)
- LO  output  32  LO register (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - busy=0, HI=0, LO=0, counter=0, pending result=0, state=IDLE.
  - An in-flight operation is discarded; HI/LO are never committed with its result.
- States: IDLE, RUN.
- IDLE, start=1, md_op in {1..4} at edge E:
  - Latch the full 64-bit result into the pending regs {p_hi,p_lo}.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from E onward.
- RUN:
  - Decrement the counter each edge.
  - At the edge where the counter reaches 0: HI<=p_hi, LO<=p_lo, busy<=0, go to IDLE.
  - busy is high for exactly N cycles. New HI/LO values are visible in cycle N+1 counting the start cycle as 0.
- mthi/mtlo (md_op 5/6, start=1, IDLE):
  - Single-cycle write: HI<=A (or LO<=A) at the next edge.
  - busy stays 0; the other register is unchanged.
- start=1 while busy=1: ignored entirely, including mthi/mtlo. The pipeline guarantees this does not happen; the unit still must not corrupt state.
- start=1 with md_op 0 or 7: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64. HI = product[63:32], LO = product[31:0].
  - multu: unsigned 32x32 -> 64, same split.
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu: unsigned; LO = quotient, HI = remainder.
  - Divide by zero (B=0, div or divu): run the full DIV_CYCLES with busy high, then leave HI and LO unchanged (no commit).
- Operands are sampled only at the start edge. Changes to A/B during RUN have no effect.
- HI/LO change only at the completion edge, on mthi/mtlo, or on reset. They are stable throughout RUN: the old values stay readable.

Decomposition:
- Shared package or header:
  - MD_OP encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - Default latency constants MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
  - State encoding IDLE/RUN.
- One natural sub-module: md_compute. Purely combinational; takes md_op, A, B; returns the 64-bit {hi,lo} result and a div_by_zero flag.
- The top level holds the FSM, counter, pending regs and HI/LO.

Test Plan:
- Reset mid-RUN:
  - start mult A=3 B=4, then reset=0 after 2 cycles, then release.
  - Required: busy=0 immediately (asynchronously), HI=LO=0, and no later commit of 12.
- mult A=0xFFFFFFFF B=2:
  - busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Same operands with multu: HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9) B=2:
  - busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Same operands with divu: LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero and overflow:
  - mthi 0x1234, mtlo 0x5678, then div A=5 B=0: busy for 10 cycles, afterwards HI=0x1234, LO=0x5678.
  - Then div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Start during busy:
  - start multu A=2 B=3.
  - While busy, pulse start mtlo A=0xDEAD and start divu A=9 B=2.
  - Required: both ignored; final HI=0, LO=6; busy drops after exactly 5 cycles.
- Back-to-back:
  - start mult on the cycle busy falls.
  - Required: the new op is accepted, busy re-asserts at the next edge, and HI/LO keep the first result until the second completes.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared encodings, latency defaults and FSM states for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Operations that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_md_compute.sv
`default_nettype none
// ============================================================================
// Module      : md_compute
// Description : Combinational 64-bit {hi,lo} result for mult/multu/div/divu,
//               plus a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  md_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_by_zero_o
);

    logic               w_b_zero;
    logic               w_ovf;
    logic [31:0]        w_divisor;
    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;

    assign w_b_zero  = (b_i == 32'd0);
    // Substitute 1 for a zero divisor so the dividers never see x/0.
    assign w_divisor = w_b_zero ? 32'd1 : b_i;
    assign w_ovf     = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign w_sa      = {{32{a_i[31]}}, a_i};
    assign w_sb      = {{32{b_i[31]}}, b_i};
    assign w_sq      = $signed(a_i) / $signed(w_divisor);
    assign w_sr      = $signed(a_i) % $signed(w_divisor);

    always_comb begin
        result_o      = 64'd0;
        div_by_zero_o = 1'b0;
        case (md_op_i)
            MD_MULT:  result_o = w_sa * w_sb;
            MD_MULTU: result_o = {32'd0, a_i} * {32'd0, b_i};
            MD_DIV: begin
                div_by_zero_o = w_b_zero;
                if (w_ovf) begin
                    result_o = {32'd0, 32'h8000_0000};
                end else begin
                    result_o = {w_sr, w_sq};
                end
            end
            MD_DIVU: begin
                div_by_zero_o = w_b_zero;
                result_o      = {a_i % w_divisor, a_i / w_divisor};
            end
            default: result_o = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Fixed-latency multiply/divide unit owning the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int C_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    md_state_e          state_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;
    logic [31:0]        p_hi_q;
    logic [31:0]        p_lo_q;
    logic               dbz_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic [63:0]        w_result;
    logic               w_dbz;
    logic [C_CNT_W-1:0] w_load;

    md_compute u_md_compute (
        .md_op_i       (md_op),
        .a_i           (A),
        .b_i           (B),
        .result_o      (w_result),
        .div_by_zero_o (w_dbz)
    );

    assign w_load = is_mult_op(md_op) ? C_CNT_W'(MULT_CYCLES) : C_CNT_W'(DIV_CYCLES);
    assign cnt_d  = cnt_q - C_CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_long_op(md_op)) begin
                            p_hi_q  <= w_result[63:32];
                            p_lo_q  <= w_result[31:0];
                            dbz_q   <= w_dbz;
                            cnt_q   <= w_load;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            hi_q <= A;
                        end else if (md_op == MD_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                ST_RUN: begin
                    // Starts arriving here are dropped; the counter alone drives completion.
                    cnt_q <= cnt_d;
                    if (cnt_q == C_CNT_W'(1)) begin
                        if (!dbz_q) begin
                            hi_q <= p_hi_q;
                            lo_q <= p_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int C_MULT_N = 5;
    localparam int C_DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(
        .MULT_CYCLES (C_MULT_N),
        .DIV_CYCLES  (C_DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on the operands.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = ua * ub;
            3'd3: begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            3'd4: begin
                uq = ua / ub;
                ur = ua % ub;
                r  = {ur[31:0], uq[31:0]};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still high after %0d cycles", n);
        end
    endtask

    // Accepted long op: push the expected completion, then issue it.
    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        e.cycles = (op == 3'd1 || op == 3'd2) ? C_MULT_N : C_DIV_N;
        if ((op == 3'd3 || op == 3'd4) && b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
        end else begin
            r    = ref_result(op, a, b);
            e.hi = r[63:32];
            e.lo = r[31:0];
        end
        m_hi = e.hi;
        m_lo = e.lo;
        exp_q.push_back(e);
        issue(op, a, b);
    endtask

    task automatic run_short(input logic [2:0] op, input logic [31:0] a);
        if (op == 3'd5) m_hi = a;
        if (op == 3'd6) m_lo = a;
        issue(op, a, $urandom);
        check("short_busy", {31'd0, busy}, 32'd0);
        check("short_hi", HI, m_hi);
        check("short_lo", LO, m_lo);
    endtask

    // Monitor: pops one expectation per busy falling edge.
    int          mon_cnt;
    logic        mon_prev;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b1) begin
            mon_prev = 1'b0;
            mon_cnt  = 0;
        end else begin
            if (busy === 1'b1) begin
                if (mon_prev !== 1'b1) begin
                    mon_cnt = 0;
                    hold_hi = HI;
                    hold_lo = LO;
                end else begin
                    check("run_stable_hi", HI, hold_hi);
                    check("run_stable_lo", LO, hold_lo);
                end
                mon_cnt++;
            end else if (mon_prev === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: HI=0x%08h LO=0x%08h", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    check("done_hi", HI, e.hi);
                    check("done_lo", LO, e.lo);
                    check("busy_cycles", mon_cnt, e.cycles);
                end
            end
            mon_prev = busy;
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_fail   = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        start    = 1'b0;
        md_op    = 3'd0;
        A        = 32'd0;
        B        = 32'd0;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_long(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
        run_long(3'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        run_long(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("div_hi", HI, 32'hFFFF_FFFF);
        check("div_lo", LO, 32'hFFFF_FFFD);
        run_long(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("divu_hi", HI, 32'h0000_0001);
        check("divu_lo", LO, 32'h7FFF_FFFC);

        run_short(3'd5, 32'h0000_1234);
        run_short(3'd6, 32'h0000_5678);
        run_long(3'd3, 32'd5, 32'd0);
        wait_idle();
        check("dbz_hi", HI, 32'h0000_1234);
        check("dbz_lo", LO, 32'h0000_5678);
        run_long(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("ovf_hi", HI, 32'h0000_0000);
        check("ovf_lo", LO, 32'h8000_0000);

        run_short(3'd0, 32'hAAAA_AAAA);
        run_short(3'd7, 32'h5555_5555);

        // Starts while busy must be ignored.
        run_long(3'd2, 32'd2, 32'd3);
        issue(3'd6, 32'h0000_DEAD, 32'd0);
        issue(3'd4, 32'd9, 32'd2);
        wait_idle();
        check("ignore_hi", HI, 32'd0);
        check("ignore_lo", LO, 32'd6);

        // Back-to-back: second start lands on the cycle busy falls.
        run_long(3'd1, 32'd7, 32'hFFFF_FFFD);
        wait_idle();
        run_long(3'd1, 32'd100, 32'd200);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_old_lo", LO, 32'hFFFF_FFEB);
        wait_idle();

        // Reset mid-run discards the operation.
        issue(3'd1, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        #2 reset = 1'b0;
        #1;
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_hi", HI, 32'd0);
        check("rst_async_lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_nocommit_hi", HI, 32'd0);
        check("rst_nocommit_lo", LO, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op >= 3'd1 && op <= 3'd4) begin
                run_long(op, a, b);
                wait_idle();
            end else begin
                run_short(op, a);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        wait_idle();
        @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
